muldiv_unit: RTL and testbench

- Parametrised RV M-extension execution unit; successor to the single-cycle integer ALU.
- Receives issued MUL/DIV/REM ops from the reservation station.
- Computes them with a pipelined multiplier and an iterative radix-2 divider.
- Broadcasts {data, rob_id} as a one-cycle result pulse on the common data bus.
- Supports variable latency, an issue handshake, stall (rdy) and rollback flush.

---
 rtl/muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV M-extension execution unit.
// MUL/MULH/MULHSU/MULHU go through a MUL_STAGES-deep pipeline. DIV/DIVU/REM/REMU
// use an iterative radix-2 restoring divider. Each accepted op retires as a
// one-cycle {out_data, out_rob_id} pulse on the common data bus.
//
// Divider FSM
//   state    | meaning
//   ---------+------------------------------------------------------------------
//   DIV_IDLE | no division in flight, unit accepts new ops
//   DIV_RUN  | one restoring step per cycle on the operand magnitudes
//   DIV_DONE | final restoring step, sign fix-up / special-case override, retire
//
// The last quotient bit is resolved in DIV_DONE, in the same cycle as the
// fix-up. This puts the result on the bus XLEN+1 cycles after acceptance.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int ROB_ID_W   = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_func3,
  input  logic [XLEN-1:0]     in_data1,
  input  logic [XLEN-1:0]     in_data2,
  input  logic [ROB_ID_W-1:0] in_rob_id,
  output logic                out_valid,
  output logic [XLEN-1:0]     out_data,
  output logic [ROB_ID_W-1:0] out_rob_id
);

  localparam int CNT_W = $clog2(XLEN);
  // DIV_RUN covers XLEN-1 steps; DIV_DONE performs the last one.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 2);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // ---------------------------------------------------------------------------
  // Issue
  // ---------------------------------------------------------------------------
  logic flush;
  logic div_busy;
  logic accept;
  logic mul_acc;
  logic div_acc;

  div_state_e div_state_q;

  assign flush    = rst || rollback;
  assign div_busy = (div_state_q != DIV_IDLE);
  assign in_ready = !div_busy;
  // An op presented in a flush cycle is dropped.
  assign accept   = rdy && in_valid && in_ready && !flush;
  assign mul_acc  = accept && !in_func3[2];
  assign div_acc  = accept && in_func3[2];

  // ---------------------------------------------------------------------------
  // Multiplier front end
  // ---------------------------------------------------------------------------
  logic                   mul_a_sgn;
  logic                   mul_b_sgn;
  logic signed [2*XLEN-1:0] mul_a;
  logic signed [2*XLEN-1:0] mul_b;
  logic signed [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]        mul_res;

  // Extend the operands to 2*XLEN with the signedness of the selected op.
  // Every M-op product fits in 2*XLEN bits.
  always_comb begin
    mul_a_sgn = (in_func3[1:0] == 2'b01) || (in_func3[1:0] == 2'b10);
    mul_b_sgn = (in_func3[1:0] == 2'b01);
    mul_a     = {{XLEN{mul_a_sgn & in_data1[XLEN-1]}}, in_data1};
    mul_b     = {{XLEN{mul_b_sgn & in_data2[XLEN-1]}}, in_data2};
    mul_prod  = mul_a * mul_b;
    if (in_func3[1:0] == 2'b00) begin
      mul_res = mul_prod[XLEN-1:0];
    end else begin
      mul_res = mul_prod[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier pipeline: MUL_STAGES-1 internal stages feed the shared output
  // register, which provides the last stage of latency.
  // ---------------------------------------------------------------------------
  logic                mul_ret_v;
  logic [XLEN-1:0]     mul_ret_data;
  logic [ROB_ID_W-1:0] mul_ret_id;

  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_ret_v    = mul_acc;
      assign mul_ret_data = mul_res;
      assign mul_ret_id   = in_rob_id;
    end else begin : g_mul_pipe
      logic [MUL_STAGES-2:0] mul_v_q;
      logic [XLEN-1:0]       mul_data_q [MUL_STAGES-1];
      logic [ROB_ID_W-1:0]   mul_id_q   [MUL_STAGES-1];

      // Advance the product pipeline on every rdy cycle. A flush kills the valids only.
      always_ff @(posedge clk) begin
        if (flush) begin
          mul_v_q <= '0;
        end else if (rdy) begin
          mul_v_q[0]    <= mul_acc;
          mul_data_q[0] <= mul_res;
          mul_id_q[0]   <= in_rob_id;
          for (int i = 1; i < MUL_STAGES - 1; i++) begin
            mul_v_q[i]    <= mul_v_q[i-1];
            mul_data_q[i] <= mul_data_q[i-1];
            mul_id_q[i]   <= mul_id_q[i-1];
          end
        end
      end

      assign mul_ret_v    = mul_v_q[MUL_STAGES-2];
      assign mul_ret_data = mul_data_q[MUL_STAGES-2];
      assign mul_ret_id   = mul_id_q[MUL_STAGES-2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  logic                div_sgn;
  logic [XLEN-1:0]     dvnd_mag;
  logic [XLEN-1:0]     dvsr_mag;

  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     rem_q;
  logic [XLEN-1:0]     quo_q;
  logic [XLEN-1:0]     dvsr_q;
  logic [XLEN-1:0]     dvnd_q;
  logic                is_rem_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic                div0_q;
  logic                ovf_q;
  logic [ROB_ID_W-1:0] div_id_q;

  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       rem_diff;
  logic [XLEN-1:0]     rem_nx;
  logic [XLEN-1:0]     quo_nx;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     div_res;
  logic                div_done;

  // Operand magnitudes for the unsigned core. func3[0] selects the unsigned variants.
  always_comb begin
    div_sgn  = !in_func3[0];
    dvnd_mag = (div_sgn && in_data1[XLEN-1]) ? -in_data1 : in_data1;
    dvsr_mag = (div_sgn && in_data2[XLEN-1]) ? -in_data2 : in_data2;
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits. Then the sign fix-up and special-case
  // override that apply when the step retires in DIV_DONE.
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, dvsr_q};
    if (!rem_diff[XLEN]) begin
      rem_nx = rem_diff[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end

    quo_fix = neg_quo_q ? -quo_nx : quo_nx;
    rem_fix = neg_rem_q ? -rem_nx : rem_nx;
    if (div0_q) begin
      quo_fix = '1;
      rem_fix = dvnd_q;
    end else if (ovf_q) begin
      quo_fix = dvnd_q;
      rem_fix = '0;
    end
    div_res  = is_rem_q ? rem_fix : quo_fix;
    div_done = (div_state_q == DIV_DONE);
  end

  // Divider FSM and datapath. Special cases still walk the full iteration count.
  always_ff @(posedge clk) begin
    if (flush) begin
      div_state_q <= DIV_IDLE;
    end else if (rdy) begin
      case (div_state_q)
        DIV_IDLE: begin
          if (div_acc) begin
            div_state_q <= DIV_RUN;
            cnt_q       <= CNT_INIT;
            rem_q       <= '0;
            quo_q       <= dvnd_mag;
            dvsr_q      <= dvsr_mag;
            dvnd_q      <= in_data1;
            is_rem_q    <= in_func3[1];
            neg_quo_q   <= div_sgn && (in_data1[XLEN-1] ^ in_data2[XLEN-1]);
            neg_rem_q   <= div_sgn && in_data1[XLEN-1];
            div0_q      <= (in_data2 == '0);
            ovf_q       <= div_sgn && (in_data1 == MIN_NEG) && (in_data2 == '1);
            div_id_q    <= in_rob_id;
          end
        end
        DIV_RUN: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            div_state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          div_state_q <= DIV_IDLE;
        end
        default: begin
          div_state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result bus
  // ---------------------------------------------------------------------------
  logic                out_valid_q;
  logic [XLEN-1:0]     out_data_q;
  logic [ROB_ID_W-1:0] out_rob_id_q;

  // Registered one-cycle result pulse. Because MUL_STAGES < XLEN+1, mul and
  // div retirements never coincide, so the priority order here is only
  // nominal.
  always_ff @(posedge clk) begin
    if (flush) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rob_id_q <= '0;
    end else if (rdy) begin
      if (mul_ret_v) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= mul_ret_data;
        out_rob_id_q <= mul_ret_id;
      end else if (div_done) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= div_res;
        out_rob_id_q <= div_id_q;
      end else begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_rob_id = out_rob_id_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32, MUL_STAGES=2).
// Inputs are driven and outputs sampled on the falling edge. Cycle T is the
// cycle whose rising edge accepts the op.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_func3;
  logic [31:0] in_data1;
  logic [31:0] in_data2;
  logic [3:0]  in_rob_id;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_rob_id;

  int vec_cnt = 0;
  int err_cnt = 0;

  muldiv_unit #(.XLEN(32), .ROB_ID_W(4), .MUL_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rollback   (rollback),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func3   (in_func3),
    .in_data1   (in_data1),
    .in_data2   (in_data2),
    .in_rob_id  (in_rob_id),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_rob_id (out_rob_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
    in_func3 = 3'b000; in_data1 = '0; in_data2 = '0; in_rob_id = '0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vec_cnt++;
    if (out_data !== 32'h0) begin err_cnt++; $display("FAIL reset_data: got %h want 0", out_data); end
    vec_cnt++;
    if (out_rob_id !== 4'h0) begin err_cnt++; $display("FAIL reset_rob_id: got %h want 0", out_rob_id); end
    vec_cnt++;
    if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  fn [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b001, 3'b001, 3'b010, 3'b000};
    logic [31:0] a  [8] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h80000000, 32'h2, 32'h12345678};
    logic [31:0] b  [8] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h100};
    logic [31:0] ex [8] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                            32'h0, 32'hC0000000, 32'h1, 32'h34567800};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_func3 = fn[i]; in_data1 = a[i]; in_data2 = b[i]; in_rob_id = 4'(i + 1);
      @(negedge clk);
      in_valid = 1'b0;
      vec_cnt++;
      if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mul_early[%0d]: valid %b want 0", i, out_valid); end
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b1 || out_data !== ex[i] || out_rob_id !== 4'(i + 1))
        begin err_cnt++; $display("FAIL mul_result[%0d]: got v=%b d=%h id=%h want v=1 d=%h id=%h",
                                   i, out_valid, out_data, out_rob_id, ex[i], 4'(i + 1)); end
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mul_pulse[%0d]: valid %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_func3 = 3'b000; in_data1 = 32'h7; in_data2 = 32'hFFFFFFFD; in_rob_id = 4'hA;
    @(negedge clk);
    in_func3 = 3'b001; in_data1 = 32'h80000000; in_data2 = 32'h80000000; in_rob_id = 4'hB;
    vec_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_early: valid %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFEB || out_rob_id !== 4'hA)
      begin err_cnt++; $display("FAIL b2b_first: got v=%b d=%h id=%h want v=1 d=ffffffeb id=a",
                                 out_valid, out_data, out_rob_id); end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h40000000 || out_rob_id !== 4'hB)
      begin err_cnt++; $display("FAIL b2b_second: got v=%b d=%h id=%h want v=1 d=40000000 id=b",
                                 out_valid, out_data, out_rob_id); end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_end: valid %b want 0", out_valid); end
  endtask

  task automatic test_div();
    logic [2:0]  fn [14] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b110, 3'b100,
                             3'b110, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a  [14] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h5, 32'h5,
                             32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                             32'h80000000, 32'h80000000};
    logic [31:0] b  [14] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'h0,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex [14] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1, 32'hFFFFFFFF, 32'h5,
                             32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h2,
                             32'h0, 32'h80000000};
    int bad_rdy;
    int bad_early;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_func3 = fn[i]; in_data1 = a[i]; in_data2 = b[i]; in_rob_id = 4'(i + 2);
      @(negedge clk);
      in_valid = 1'b0;
      bad_rdy = 0; bad_early = 0;
      for (int c = 1; c <= 32; c++) begin
        if (in_ready !== 1'b0) bad_rdy++;
        if (out_valid !== 1'b0) bad_early++;
        @(negedge clk);
      end
      vec_cnt++;
      if (bad_rdy != 0 || bad_early != 0)
        begin err_cnt++; $display("FAIL div_busy_window[%0d]: in_ready high %0d cycles, early valid %0d cycles, want 0/0",
                                   i, bad_rdy, bad_early); end
      vec_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== ex[i] || out_rob_id !== 4'(i + 2))
        begin err_cnt++; $display("FAIL div_result[%0d]: got v=%b rdy=%b d=%h id=%h want v=1 rdy=1 d=%h id=%h",
                                   i, out_valid, in_ready, out_data, out_rob_id, ex[i], 4'(i + 2)); end
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL div_pulse[%0d]: valid %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_mixed();
    int bad;
    in_valid = 1'b1; in_func3 = 3'b000; in_data1 = 32'd6; in_data2 = 32'd7; in_rob_id = 4'h3;
    @(negedge clk);                                   // T+1
    in_func3 = 3'b101; in_data1 = 32'd100; in_data2 = 32'd7; in_rob_id = 4'h4;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin err_cnt++; $display("FAIL mix_t1: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    @(negedge clk);                                   // T+2
    in_func3 = 3'b011; in_data1 = 32'h10000; in_data2 = 32'h10000; in_rob_id = 4'h5;
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'd42 || out_rob_id !== 4'h3)
      begin err_cnt++; $display("FAIL mix_mul: got v=%b d=%h id=%h want v=1 d=0000002a id=3",
                                 out_valid, out_data, out_rob_id); end
    bad = 0;
    for (int c = 2; c <= 33; c++) begin
      if (in_ready !== 1'b0) bad++;
      if (c >= 3 && out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    // now T+34
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL mix_busy: %0d bad cycles want 0", bad); end
    vec_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'd14 || out_rob_id !== 4'h4)
      begin err_cnt++; $display("FAIL mix_div: got v=%b rdy=%b d=%h id=%h want v=1 rdy=1 d=0000000e id=4",
                                 out_valid, in_ready, out_data, out_rob_id); end
    @(negedge clk);                                   // T+35
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL mix_gap: valid %b want 0", out_valid); end
    @(negedge clk);                                   // T+36
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h1 || out_rob_id !== 4'h5)
      begin err_cnt++; $display("FAIL mix_held: got v=%b d=%h id=%h want v=1 d=00000001 id=5",
                                 out_valid, out_data, out_rob_id); end
    @(negedge clk);
  endtask

  task automatic test_rollback();
    int bad;
    in_valid = 1'b1; in_func3 = 3'b100; in_data1 = 32'd100; in_data2 = 32'd7; in_rob_id = 4'h6;
    @(negedge clk);                                   // T+1
    in_valid = 1'b0;
    bad = 0;
    for (int c = 1; c < 10; c++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    rollback = 1'b1;                                  // T+10
    @(negedge clk);                                   // T+11
    rollback = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || out_rob_id !== 4'h0)
      begin err_cnt++; $display("FAIL rb_div_clear: got rdy=%b v=%b d=%h id=%h want rdy=1 v=0 d=0 id=0",
                                 in_ready, out_valid, out_data, out_rob_id); end
    for (int c = 11; c <= 40; c++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL rb_div_silent: %0d result pulses want 0", bad); end

    in_valid = 1'b1; in_func3 = 3'b000; in_data1 = 32'd3; in_data2 = 32'd5; in_rob_id = 4'h7;
    @(negedge clk);
    in_valid = 1'b0; rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL rb_mul_silent: %0d result pulses want 0", bad); end

    in_valid = 1'b1; rollback = 1'b1; in_func3 = 3'b000; in_data1 = 32'd3; in_data2 = 32'd5; in_rob_id = 4'h8;
    @(negedge clk);
    in_valid = 1'b0; rollback = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL rb_drop_issue: %0d result pulses want 0", bad); end

    in_valid = 1'b1; in_func3 = 3'b000; in_data1 = 32'd3; in_data2 = 32'd5; in_rob_id = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'd15 || out_rob_id !== 4'h9)
      begin err_cnt++; $display("FAIL rb_recover: got v=%b d=%h id=%h want v=1 d=0000000f id=9",
                                 out_valid, out_data, out_rob_id); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int bad;
    in_valid = 1'b1; in_func3 = 3'b000; in_data1 = 32'h12345; in_data2 = 32'h10; in_rob_id = 4'hC;
    @(negedge clk);                                   // T+1
    in_func3 = 3'b011; in_data1 = 32'hFFFFFFFF; in_data2 = 32'h2; in_rob_id = 4'hD;
    rdy = 1'b0;
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      if (out_valid !== 1'b0) bad++;
      if (c < 4) @(negedge clk);
    end
    rdy = 1'b1; in_valid = 1'b0;                      // at T+4
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL stall_early: %0d early pulses want 0", bad); end
    @(negedge clk);                                   // T+5
    vec_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h123450 || out_rob_id !== 4'hC)
      begin err_cnt++; $display("FAIL stall_result: got v=%b d=%h id=%h want v=1 d=00123450 id=c",
                                 out_valid, out_data, out_rob_id); end
    @(negedge clk);                                   // T+6
    vec_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_pulse: valid %b want 0", out_valid); end
    @(negedge clk);                                   // T+7
    vec_cnt++;
    if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_no_extra: valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_div();
    int bad;
    in_valid = 1'b1; in_func3 = 3'b100; in_data1 = 32'd100; in_data2 = 32'd7; in_rob_id = 4'hE;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);                        // T+10
    rst = 1'b1;
    @(negedge clk);                                   // T+11
    rst = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_rob_id !== 4'h0 || in_ready !== 1'b1)
      begin err_cnt++; $display("FAIL rst_mid_div: got v=%b d=%h id=%h rdy=%b want v=0 d=0 id=0 rdy=1",
                                 out_valid, out_data, out_rob_id, in_ready); end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    vec_cnt++;
    if (bad != 0) begin err_cnt++; $display("FAIL rst_div_silent: %0d result pulses want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_div();
    test_mixed();
    test_rollback();
    test_stall();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
